traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised N-approach intersection signal controller with an integrated phase timer. It cycles green/yellow round-robin through approaches, skips approaches with no vehicle demand, and inserts an exclusive all-approach pedestrian walk phase when requests are pending. It sits between the sensor front-end (vehicle presence, pedestrian buttons, prescaled tick) and the lamp drivers in the city-simulation top level.

## Interface
- NUM_APPROACHES, 4, number of approaches (≥2)
- TW, 8, phase-timer width
- GREEN_TICKS, 20, green duration in ticks
- YELLOW_TICKS, 4, yellow duration in ticks
- ALLRED_TICKS, 2, all-red clearance in ticks (used only with TRAFFIC_ALLRED_EN)
- WALK_TICKS, 10, pedestrian walk duration in ticks
- All durations are 1..2^TW.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  timer enable; one-cycle strobe from prescaler
- car_present  in  NUM_APPROACHES  vehicle demand per approach (level)
- ped_request  in  NUM_APPROACHES  pedestrian button per approach (pulse or level)
- green  out  NUM_APPROACHES  one-hot green lamp, 0 when not GREEN
- yellow  out  NUM_APPROACHES  one-hot yellow lamp, 0 when not YELLOW
- walk  out  NUM_APPROACHES  walk lamps, nonzero only in WALK
- ped_pending  out  NUM_APPROACHES  latched unserved pedestrian requests
- phase_idx  out  $clog2(NUM_APPROACHES)  currently owning approach

## Operation
- States: GREEN, YELLOW, ALLRED, WALK. Reset: GREEN, phase_idx=0, timer=GREEN_TICKS-1, ped_pending=0, walk_mask=0; thus green=bit0, yellow=0, walk=0.
- Every state entry loads timer with duration-1. Expiry = tick && timer==0; otherwise tick decrements.
- GREEN expiry → YELLOW (same phase_idx).
- YELLOW expiry → ALLRED if TRAFFIC_ALLRED_EN, else treated as clearance exit.
- Clearance exit: if ped_pending≠0 → WALK, walk_mask←ped_pending; else → GREEN of next approach.
- WALK: walk=walk_mask; expiry clears walk_mask bits from ped_pending, → GREEN of next approach.
- Next approach: first index after phase_idx (wrapping) with car_present=1; if none set, phase_idx+1 mod N. Sampled on the transition cycle.
- ped_pending[i] set on any cycle ped_request[i]=1, except during WALK when walk_mask[i]=1 (ignored, already being served). A request arriving on the WALK-exit cycle for a non-walking bit is retained.
- Lamp outputs are pure decodes of registered state/phase_idx/walk_mask; never two approaches green or yellow together; green/yellow never overlap walk.

## Timing
- With tick tied high, GREEN lasts GREEN_TICKS cycles, YELLOW YELLOW_TICKS, etc. Generally each state lasts exactly duration ticks plus cycles until the next tick-expiry edge.
- ped_pending rises one cycle after ped_request.
- Reset mid-phase: outputs return to reset values immediately (asynchronous); first tick after release counts toward GREEN.
- car_present changes affect only the next selection; never abort a running phase.

## Configuration
- TRAFFIC_ALLRED_EN defined: ALLRED state present between YELLOW and WALK/GREEN, all lamps red for ALLRED_TICKS.
- Not defined: ALLRED state and ALLRED_TICKS unused; YELLOW expiry goes directly to WALK or GREEN.

## Structure
- traffic_pkg: state enum (GREEN, YELLOW, ALLRED, WALK), default duration constants.
- Sub-module traffic_timer: TW-bit down counter with load, load value, tick, done output; instantiated once.
- Round-robin selection and request latching stay in the top module.

## Test plan
- N=4, GREEN=5, YELLOW=2, ALLRED=1 (macro on), tick=1, car_present=1111, no peds → green=0001 5 cycles, yellow=0001 2, all zero 1, then green=0010.
- Same, car_present=0100 during phase 0 → after clearance green=0100, phase_idx=2.
- Pulse ped_request[3] in phase-0 green → ped_pending=1000 next cycle; after clearance walk=1000 for WALK=3 cycles, green/yellow=0; then green=0010, ped_pending=0000.
- During that walk pulse ped_request[3] and ped_request[1] → bit3 ignored, ped_pending=0010 after walk; served after next yellow/all-red.
- tick every 4th cycle, GREEN=5 → green held 20 cycles (±phase alignment of first tick).
- Assert rst mid-YELLOW of phase 2 with ped_pending=0001 → immediately green=0001, yellow=0, ped_pending=0, phase_idx=0.

Source files
------------

// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types and default timing constants for the intersection phase controller.
package traffic_phase_ctrl_pkg;

  // Controller phases; ALLRED is only entered when TRAFFIC_ALLRED_EN is built in.
  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_WALK   = 2'd3
  } phase_e;

  localparam int DEF_NUM_APPROACHES = 4;
  localparam int DEF_TW             = 8;
  localparam int DEF_GREEN_TICKS    = 20;
  localparam int DEF_YELLOW_TICKS   = 4;
  localparam int DEF_ALLRED_TICKS   = 2;
  localparam int DEF_WALK_TICKS     = 10;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Sensor-side / lamp-side signal bundle of the phase controller.
// master: sensor front-end (drives tick and demand), slave: the controller.
interface traffic_phase_ctrl_if #(
  parameter int NUM_APPROACHES = 4
);
  localparam int IW = $clog2(NUM_APPROACHES);

  logic                      tick;
  logic [NUM_APPROACHES-1:0] car_present;
  logic [NUM_APPROACHES-1:0] ped_request;
  logic [NUM_APPROACHES-1:0] green;
  logic [NUM_APPROACHES-1:0] yellow;
  logic [NUM_APPROACHES-1:0] walk;
  logic [NUM_APPROACHES-1:0] ped_pending;
  logic [IW-1:0]             phase_idx;

  modport master (
    output tick, car_present, ped_request,
    input  green, yellow, walk, ped_pending, phase_idx
  );

  modport slave (
    input  tick, car_present, ped_request,
    output green, yellow, walk, ped_pending, phase_idx
  );

endinterface

// File: rtl/traffic_phase_ctrl_timer.sv
// Phase timer: TW-bit down counter. A load always wins; otherwise each tick
// steps toward zero. done flags the expiring tick (tick while already at zero).
module traffic_phase_ctrl_timer #(
  parameter int             TW      = 8,
  parameter logic [TW-1:0]  RST_VAL = {TW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic          done
);

  logic [TW-1:0] count_r;

  // Count register: reset to the first green's reload value, reload on phase entry, tick down otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= RST_VAL;
    end else if (load) begin
      count_r <= load_val;
    end else if (tick && (count_r != {TW{1'b0}})) begin
      count_r <= count_r - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = tick && (count_r == {TW{1'b0}});

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach intersection controller: round-robin green/yellow with demand
// skipping and an exclusive pedestrian walk phase.
// Optional feature macro: TRAFFIC_ALLRED_EN adds an all-red clearance phase
// between YELLOW and the next WALK/GREEN.
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int NUM_APPROACHES = DEF_NUM_APPROACHES,
  parameter int TW             = DEF_TW,
  parameter int GREEN_TICKS    = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS   = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS   = DEF_ALLRED_TICKS,
  parameter int WALK_TICKS     = DEF_WALK_TICKS
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_phase_ctrl_if.slave  bus
);

  localparam int N  = NUM_APPROACHES;
  localparam int IW = $clog2(NUM_APPROACHES);

  localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] WALK_LD   = TW'(WALK_TICKS - 1);
  localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  NONE      = {N{1'b0}};

  // First approach after cur (wrapping, excluding cur) with demand; cur+1 when nobody waits.
  function automatic logic [IW-1:0] next_approach(input logic [IW-1:0] cur,
                                                  input logic [N-1:0]  car);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand_idx;
    logic          found;
    int            cand;
    cand  = (int'(cur) + 1) % N;
    pick  = IW'(cand);
    found = 1'b0;
    for (int k = 1; k < N; k++) begin
      cand     = (int'(cur) + k) % N;
      cand_idx = IW'(cand);
      if (!found && car[cand_idx]) begin
        pick  = cand_idx;
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

  phase_e        state_r, state_nxt_s;
  logic [IW-1:0] phase_idx_r, phase_nxt_s, next_app_s, clr_phase_s;
  logic [N-1:0]  walk_mask_r, walk_mask_nxt_s, clr_mask_s;
  logic [N-1:0]  ped_pending_r, pend_nxt_s, ped_ignore_s, walk_clear_s;
  logic [N-1:0]  green_r, yellow_r, walk_r;
  logic [N-1:0]  green_nxt_s, yellow_nxt_s, walk_nxt_s;
  phase_e        clr_state_s;
  logic [TW-1:0] clr_val_s, tmr_val_s;
  logic          tmr_load_s, tmr_done_s;

  traffic_phase_ctrl_timer #(
    .TW      (TW),
    .RST_VAL (GREEN_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tick     (bus.tick),
    .done     (tmr_done_s)
  );

  // Next demanded approach, sampled on whichever cycle a green hand-over happens.
  always_comb begin
    next_app_s = next_approach(phase_idx_r, bus.car_present);
  end

  // Clearance exit target: waiting pedestrians are served before the next green.
  always_comb begin
    clr_state_s = PH_GREEN;
    clr_mask_s  = NONE;
    clr_phase_s = next_app_s;
    clr_val_s   = GREEN_LD;
    if (ped_pending_r != NONE) begin
      clr_state_s = PH_WALK;
      clr_mask_s  = ped_pending_r;
      clr_phase_s = phase_idx_r;
      clr_val_s   = WALK_LD;
    end else begin
      clr_state_s = PH_GREEN;
      clr_mask_s  = NONE;
      clr_phase_s = next_app_s;
      clr_val_s   = GREEN_LD;
    end
  end

  // Phase sequencing and pedestrian request bookkeeping.
  always_comb begin
    state_nxt_s     = state_r;
    phase_nxt_s     = phase_idx_r;
    walk_mask_nxt_s = walk_mask_r;
    walk_clear_s    = NONE;
    tmr_load_s      = 1'b0;
    tmr_val_s       = GREEN_LD;
    if (state_r == PH_WALK) begin
      ped_ignore_s = walk_mask_r;
    end else begin
      ped_ignore_s = NONE;
    end
    case (state_r)
      PH_GREEN: begin
        if (tmr_done_s) begin
          state_nxt_s = PH_YELLOW;
          tmr_load_s  = 1'b1;
          tmr_val_s   = YELLOW_LD;
        end else begin
          state_nxt_s = PH_GREEN;
        end
      end
      PH_YELLOW: begin
        if (tmr_done_s) begin
`ifdef TRAFFIC_ALLRED_EN
          state_nxt_s     = PH_ALLRED;
          tmr_load_s      = 1'b1;
          tmr_val_s       = ALLRED_LD;
`else
          state_nxt_s     = clr_state_s;
          phase_nxt_s     = clr_phase_s;
          walk_mask_nxt_s = clr_mask_s;
          tmr_load_s      = 1'b1;
          tmr_val_s       = clr_val_s;
`endif
        end else begin
          state_nxt_s = PH_YELLOW;
        end
      end
      PH_ALLRED: begin
        if (tmr_done_s) begin
          state_nxt_s     = clr_state_s;
          phase_nxt_s     = clr_phase_s;
          walk_mask_nxt_s = clr_mask_s;
          tmr_load_s      = 1'b1;
          tmr_val_s       = clr_val_s;
        end else begin
          state_nxt_s = PH_ALLRED;
        end
      end
      PH_WALK: begin
        if (tmr_done_s) begin
          state_nxt_s     = PH_GREEN;
          phase_nxt_s     = next_app_s;
          walk_mask_nxt_s = NONE;
          walk_clear_s    = walk_mask_r;
          tmr_load_s      = 1'b1;
          tmr_val_s       = GREEN_LD;
        end else begin
          state_nxt_s = PH_WALK;
        end
      end
      default: begin
        // Unknown phase: fall back to all lamps red and a normal clearance exit.
        state_nxt_s     = PH_ALLRED;
        walk_mask_nxt_s = NONE;
        tmr_load_s      = 1'b1;
        tmr_val_s       = ALLRED_LD;
      end
    endcase
    pend_nxt_s = (ped_pending_r | (bus.ped_request & ~ped_ignore_s)) & ~walk_clear_s;
  end

  // Lamp decode of the upcoming phase so the lamp registers track the state registers.
  always_comb begin
    if (state_nxt_s == PH_GREEN) begin
      green_nxt_s = ONE_HOT0 << phase_nxt_s;
    end else begin
      green_nxt_s = NONE;
    end
    if (state_nxt_s == PH_YELLOW) begin
      yellow_nxt_s = ONE_HOT0 << phase_nxt_s;
    end else begin
      yellow_nxt_s = NONE;
    end
    if (state_nxt_s == PH_WALK) begin
      walk_nxt_s = walk_mask_nxt_s;
    end else begin
      walk_nxt_s = NONE;
    end
  end

  // Controller state, pending requests and registered lamp outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= PH_GREEN;
      phase_idx_r   <= {IW{1'b0}};
      walk_mask_r   <= NONE;
      ped_pending_r <= NONE;
      green_r       <= ONE_HOT0;
      yellow_r      <= NONE;
      walk_r        <= NONE;
    end else begin
      state_r       <= state_nxt_s;
      phase_idx_r   <= phase_nxt_s;
      walk_mask_r   <= walk_mask_nxt_s;
      ped_pending_r <= pend_nxt_s;
      green_r       <= green_nxt_s;
      yellow_r      <= yellow_nxt_s;
      walk_r        <= walk_nxt_s;
    end
  end

  assign bus.green       = green_r;
  assign bus.yellow      = yellow_r;
  assign bus.walk        = walk_r;
  assign bus.ped_pending = ped_pending_r;
  assign bus.phase_idx   = phase_idx_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a model.
module tb_traffic_phase_ctrl;

  localparam int N  = 4;
  localparam int TW = 8;
  localparam int GT = 5;
  localparam int YT = 2;
  localparam int AT = 1;
  localparam int WT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl_if #(.NUM_APPROACHES(N)) bus ();

  traffic_phase_ctrl #(
    .NUM_APPROACHES (N),
    .TW             (TW),
    .GREEN_TICKS    (GT),
    .YELLOW_TICKS   (YT),
    .ALLRED_TICKS   (AT),
    .WALK_TICKS     (WT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  // m_ph: 0 green, 1 yellow, 2 all-red, 3 walk. m_left: ticks still owed to the phase.
  int           m_ph, m_idx, m_left;
  bit [N-1:0]   m_pend, m_wmask;

  function automatic void m_reset();
    m_ph = 0; m_idx = 0; m_left = GT; m_pend = '0; m_wmask = '0;
  endfunction

  function automatic int m_next(int cur, bit [N-1:0] car);
    for (int k = 1; k < N; k++)
      if (car[(cur + k) % N]) return (cur + k) % N;
    return (cur + 1) % N;
  endfunction

  function automatic void m_green(bit [N-1:0] car);
    m_idx = m_next(m_idx, car); m_ph = 0; m_left = GT;
  endfunction

  function automatic void m_clear(bit [N-1:0] car);
    if (m_pend != 0) begin m_ph = 3; m_wmask = m_pend; m_left = WT; end
    else m_green(car);
  endfunction

  function automatic void m_step(bit t, bit [N-1:0] car, bit [N-1:0] req);
    bit [N-1:0] np;
    np = m_pend | (req & ~((m_ph == 3) ? m_wmask : 4'h0));
    if (t) begin
      if (m_left > 1) m_left--;
      else begin
        case (m_ph)
          0: begin m_ph = 1; m_left = YT; end
`ifdef TRAFFIC_ALLRED_EN
          1: begin m_ph = 2; m_left = AT; end
`else
          1: m_clear(car);
`endif
          2: m_clear(car);
          default: begin np = np & ~m_wmask; m_wmask = '0; m_green(car); end
        endcase
      end
    end
    m_pend = np;
  endfunction

  function automatic logic [31:0] m_exp();
    bit [N-1:0] g, y, w;
    bit [1:0]   ix;
    g  = (m_ph == 0) ? (4'h1 << m_idx) : 4'h0;
    y  = (m_ph == 1) ? (4'h1 << m_idx) : 4'h0;
    w  = (m_ph == 3) ? m_wmask : 4'h0;
    ix = 2'(m_idx);
    return {14'd0, g, y, w, m_pend, ix};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {14'd0, bus.green, bus.yellow, bus.walk, bus.ped_pending, bus.phase_idx};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit t, input bit [N-1:0] car, input bit [N-1:0] req);
    bus.tick = t; bus.car_present = car; bus.ped_request = req;
    @(posedge clk);
    m_step(t, car, req);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tick = 1'b0; bus.car_present = '0; bus.ped_request = '0;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit [N-1:0] car, req, g, y, w, p;
    bit [1:0]   idx;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit [3:0] car, bit [3:0] req, bit [3:0] g, bit [3:0] y,
                              bit [3:0] w, bit [3:0] p, bit [1:0] idx);
    vec_t v;
    v.car = car; v.req = req; v.g = g; v.y = y; v.w = w; v.p = p; v.idx = idx;
    vq.push_back(v);
  endfunction

  function automatic void build_table();
    // all approaches busy: 5 green, 2 yellow, (all-red), green moves to approach 1
    for (int i = 0; i < 4; i++) add(4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 2'd0);
    for (int i = 0; i < 2; i++) add(4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 2'd0);
`ifdef TRAFFIC_ALLRED_EN
    add(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
`endif
    add(4'hF, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 2'd1);
    // only approach 0 waiting: selection wraps past 2 and 3 back to 0
    for (int i = 0; i < 4; i++) add(4'h1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 2'd1);
    for (int i = 0; i < 2; i++) add(4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 2'd1);
`ifdef TRAFFIC_ALLRED_EN
    add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1);
`endif
    add(4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 2'd0);
    // pedestrian on approach 3 during phase-0 green, served by a walk phase
    add(4'hF, 4'h8, 4'h1, 4'h0, 4'h0, 4'h8, 2'd0);
    for (int i = 0; i < 3; i++) add(4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h8, 2'd0);
    for (int i = 0; i < 2; i++) add(4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 4'h8, 2'd0);
`ifdef TRAFFIC_ALLRED_EN
    add(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 2'd0);
`endif
    add(4'hF, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 2'd0);
    // during the walk: bit3 already served, bit1 latched for later
    add(4'hF, 4'hA, 4'h0, 4'h0, 4'h8, 4'hA, 2'd0);
    add(4'hF, 4'h0, 4'h0, 4'h0, 4'h8, 4'hA, 2'd0);
    add(4'hF, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 2'd1);
    // approach 1 phase, then the retained request for approach 1 walks
    for (int i = 0; i < 4; i++) add(4'hF, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 2'd1);
    for (int i = 0; i < 2; i++) add(4'hF, 4'h0, 4'h0, 4'h2, 4'h0, 4'h2, 2'd1);
`ifdef TRAFFIC_ALLRED_EN
    add(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 2'd1);
`endif
    for (int i = 0; i < 3; i++) add(4'hF, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 2'd1);
    add(4'hF, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 2'd2);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int  gcount;
    bit  done_flag, seen_g2, pulsed, reached;
    bit [N-1:0] req;

    build_table();

    // reset state
    do_reset();
    check("rst_green",  32'(bus.green),       32'h1);
    check("rst_yellow", 32'(bus.yellow),      32'h0);
    check("rst_walk",   32'(bus.walk),        32'h0);
    check("rst_pend",   32'(bus.ped_pending), 32'h0);
    check("rst_idx",    32'(bus.phase_idx),   32'h0);

    // directed table, tick tied high
    for (int i = 0; i < vq.size(); i++) begin
      step(1'b1, vq[i].car, vq[i].req);
      check($sformatf("vec%0d", i), dut_vec(),
            {14'd0, vq[i].g, vq[i].y, vq[i].w, vq[i].p, vq[i].idx});
    end

    // tick every 4th cycle: green held for GT*4 samples
    do_reset();
    gcount = (bus.green == 4'h1) ? 1 : 0;
    done_flag = 1'b0;
    for (int c = 1; c <= 60 && !done_flag; c++) begin
      step((c % 4) == 0, 4'hF, 4'h0);
      check($sformatf("slow_tick%0d", c), dut_vec(), m_exp());
      if (bus.green == 4'h1) gcount++;
      else done_flag = 1'b1;
    end
    check("green_hold_tick4", 32'(gcount), 32'd20);
    check("yellow_after_hold", 32'(bus.yellow), 32'h1);

    // reset asserted mid-yellow of phase 2 with a pending request
    do_reset();
    seen_g2 = 1'b0; pulsed = 1'b0; reached = 1'b0;
    for (int c = 0; c < 60 && !reached; c++) begin
      req = (seen_g2 && !pulsed) ? 4'h1 : 4'h0;
      if (req != 0) pulsed = 1'b1;
      step(1'b1, 4'h4, req);
      check($sformatf("to_y2_%0d", c), dut_vec(), m_exp());
      if (bus.green == 4'h4) seen_g2 = 1'b1;
      if (bus.yellow == 4'h4) reached = 1'b1;
    end
    check("reached_y2", 32'(reached), 32'h1);
    check("pend_before_rst", 32'(bus.ped_pending), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_green",  32'(bus.green),       32'h1);
    check("arst_yellow", 32'(bus.yellow),      32'h0);
    check("arst_pend",   32'(bus.ped_pending), 32'h0);
    check("arst_idx",    32'(bus.phase_idx),   32'h0);
    check("arst_walk",   32'(bus.walk),        32'h0);
    #2 rst = 1'b0;
    m_reset();
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 4'hF, 4'h0);
      check($sformatf("post_rst%0d", c), dut_vec(), m_exp());
    end

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit         t;
      bit [N-1:0] car, rq;
      t   = ($urandom_range(0, 2) != 0);
      car = 4'($urandom);
      rq  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      step(t, car, rq);
      check($sformatf("rand%0d", c), dut_vec(), m_exp());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
